// File: rtl/rambus_pkg.sv
// Shared types and constants for the rambus arbiter in front of OpenRAM port B.
package rambus_pkg;

    localparam int RAMBUS_ADDR_W = 10;
    localparam int RAMBUS_DATA_W = 32;
    localparam int RAMBUS_SEL_W  = 4;
    localparam int WDOG_W        = 8;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request above the pointer, with wrap-around.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic          valid_o
);

    logic [PW-1:0] idx;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int i = 1; i <= N; i++) begin
            idx = PW'((int'(ptr_i) + i) % N);
            if (!valid_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rambus_arbiter.sv
// Round-robin Wishbone arbiter sharing the OpenRAM port B between user-project masters,
// with a per-access watchdog so a silent slave cannot lock the RAM.
module rambus_arbiter
    import rambus_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = RAMBUS_ADDR_W,
    parameter int DATA_WIDTH  = RAMBUS_DATA_W,
    parameter int TIMEOUT     = 255
) (
    input  logic                              wb_clk_i,
    input  logic                              wb_rst_n_i,
    input  logic [NUM_MASTERS-1:0]            en_i,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] m_sel_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic [DATA_WIDTH-1:0]             m_dat_o,
    output logic                              s_cyc_o,
    output logic                              s_stb_o,
    output logic                              s_we_o,
    output logic [DATA_WIDTH/8-1:0]           s_sel_o,
    output logic [ADDR_WIDTH-1:0]             s_adr_o,
    output logic [DATA_WIDTH-1:0]             s_dat_o,
    input  logic                              s_ack_i,
    input  logic [DATA_WIDTH-1:0]             s_dat_i,
    output logic [NUM_MASTERS-1:0]            grant_o
);

    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int PW    = $clog2(NUM_MASTERS);

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [WDOG_W-1:0]      wdog_q, wdog_d;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] pick_gnt;
    logic                   pick_valid;

    logic [PW-1:0]          grant_idx;
    logic                   cyc_g, stb_g, we_g;
    logic [SEL_W-1:0]       sel_g;
    logic [ADDR_WIDTH-1:0]  adr_g;
    logic [DATA_WIDTH-1:0]  dat_g;
    logic                   in_grant, stall, timeout;

    assign req = m_cyc_i & en_i;

    rr_pick #(
        .N  (NUM_MASTERS),
        .PW (PW)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .valid_o (pick_valid)
    );

    // grant_q is all-zero outside GRANT, so this mux also yields idle-zero slave outputs.
    always_comb begin
        grant_idx = '0;
        cyc_g     = 1'b0;
        stb_g     = 1'b0;
        we_g      = 1'b0;
        sel_g     = '0;
        adr_g     = '0;
        dat_g     = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (grant_q[k]) begin
                grant_idx = PW'(k);
                cyc_g     = m_cyc_i[k];
                stb_g     = m_stb_i[k];
                we_g      = m_we_i[k];
                sel_g     = m_sel_i[k*SEL_W +: SEL_W];
                adr_g     = m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                dat_g     = m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // An ack in the final stalled cycle is not a stall, so the ack wins over the watchdog.
    assign in_grant = (state_q == ARB_GRANT);
    assign stall    = in_grant & stb_g & ~s_ack_i;
    assign timeout  = stall & (wdog_q == WDOG_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        wdog_d  = '0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_gnt;
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (!cyc_g || timeout) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    ptr_d   = grant_idx;
                end else if (stall) begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= PW'(NUM_MASTERS - 1);
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            wdog_q  <= wdog_d;
        end
    end

    assign s_cyc_o = cyc_g & ~timeout;
    assign s_stb_o = stb_g & ~timeout;
    assign s_we_o  = we_g;
    assign s_sel_o = sel_g;
    assign s_adr_o = adr_g;
    assign s_dat_o = dat_g;
    assign m_ack_o = grant_q & {NUM_MASTERS{s_ack_i}};
    assign m_err_o = grant_q & {NUM_MASTERS{timeout}};
    assign m_dat_o = s_dat_i;
    assign grant_o = grant_q;

endmodule

// File: tb/tb_rambus_arbiter.sv
// Directed self-checking bench for rambus_arbiter (4 masters, watchdog TIMEOUT=8).
module tb_rambus_arbiter;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    en, m_cyc, m_stb, m_we;
    logic [N*SW-1:0] m_sel;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat;
    logic [N-1:0]    m_ack, m_err, grant;
    logic [DW-1:0]   m_dat_o;
    logic            s_cyc, s_stb, s_we, s_ack;
    logic [SW-1:0]   s_sel;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_dat_o, s_dat_i;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rambus_arbiter #(
        .NUM_MASTERS (N),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .TIMEOUT     (TO)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .en_i       (en),
        .m_cyc_i    (m_cyc),
        .m_stb_i    (m_stb),
        .m_we_i     (m_we),
        .m_sel_i    (m_sel),
        .m_adr_i    (m_adr),
        .m_dat_i    (m_dat),
        .m_ack_o    (m_ack),
        .m_err_o    (m_err),
        .m_dat_o    (m_dat_o),
        .s_cyc_o    (s_cyc),
        .s_stb_o    (s_stb),
        .s_we_o     (s_we),
        .s_sel_o    (s_sel),
        .s_adr_o    (s_adr),
        .s_dat_o    (s_dat_o),
        .s_ack_i    (s_ack),
        .s_dat_i    (s_dat_i),
        .grant_o    (grant)
    );

    task automatic drive_m(input int k, input logic cyc, input logic stb, input logic we,
                           input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                           input logic [SW-1:0] sel);
        m_cyc[k]           = cyc;
        m_stb[k]           = stb;
        m_we[k]            = we;
        m_adr[k*AW +: AW]  = adr;
        m_dat[k*DW +: DW]  = dat;
        m_sel[k*SW +: SW]  = sel;
    endtask

    task automatic clear_inputs();
        en      = '1;
        m_cyc   = '0;
        m_stb   = '0;
        m_we    = '0;
        m_sel   = '0;
        m_adr   = '0;
        m_dat   = '0;
        s_ack   = 1'b0;
        s_dat_i = '0;
    endtask

    // Leaves the bench at posedge+1 with the arbiter idle and pointer at master 3.
    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #12;
        n_checks++;
        if (grant !== 4'b0000 || s_cyc !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held: grant_o=%b s_cyc_o=%b, expected 0000/0", grant, s_cyc);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_o, m_ack, m_err, grant} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h ack=%b err=%b grant=%b, expected all 0",
                     s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_o, m_ack, m_err, grant);
        end
        drive_m(0, 1'b1, 1'b1, 1'b1, 10'h005, 32'hDEADBEEF, 4'hF);
        #1;
        n_checks++;
        if (grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL first_grant_latency: grant_o=%b, expected 0000 before the edge", grant);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (grant !== 4'b0001 || s_cyc !== 1'b1 || s_stb !== 1'b1 || s_we !== 1'b1) begin
            n_fail++;
            $display("FAIL m0_grant: grant_o=%b cyc=%b stb=%b we=%b, expected 0001/1/1/1", grant, s_cyc, s_stb, s_we);
        end
        n_checks++;
        if (s_adr !== 10'h005 || s_dat_o !== 32'hDEADBEEF || s_sel !== 4'hF) begin
            n_fail++;
            $display("FAIL m0_mux: adr=%h dat=%h sel=%h, expected 005/deadbeef/f", s_adr, s_dat_o, s_sel);
        end
        n_checks++;
        if (m_ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL m0_ack_low: m_ack_o=%b, expected 0000", m_ack);
        end
        s_ack   = 1'b1;
        s_dat_i = 32'h12345678;
        #1;
        n_checks++;
        if (m_ack !== 4'b0001 || m_dat_o !== 32'h12345678) begin
            n_fail++;
            $display("FAIL m0_ack_high: m_ack_o=%b m_dat_o=%h, expected 0001/12345678", m_ack, m_dat_o);
        end
        @(posedge clk);
        #1;
        s_ack = 1'b0;
        drive_m(0, 1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 4'h0);
        #1;
        n_checks++;
        if (grant !== 4'b0001 || s_cyc !== 1'b0) begin
            n_fail++;
            $display("FAIL m0_release_cycle: grant_o=%b s_cyc_o=%b, expected 0001/0", grant, s_cyc);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL m0_released: grant_o=%b, expected 0000", grant);
        end
    endtask

    task automatic test_round_robin();
        int exp_order [4] = '{0, 1, 2, 0};
        logic [N-1:0] exp_g;
        apply_reset();
        for (int k = 0; k < 3; k++) drive_m(k, 1'b1, 1'b1, 1'b0, AW'(k), DW'(k), 4'hF);
        for (int i = 0; i < 4; i++) begin
            exp_g = N'(1) << exp_order[i];
            @(posedge clk);
            #1;
            n_checks++;
            if (grant !== exp_g) begin
                n_fail++;
                $display("FAIL rr_grant_%0d: grant_o=%b, expected %b", i, grant, exp_g);
            end
            s_ack = 1'b1;
            #1;
            n_checks++;
            if (m_ack !== exp_g) begin
                n_fail++;
                $display("FAIL rr_ack_%0d: m_ack_o=%b, expected %b", i, m_ack, exp_g);
            end
            @(posedge clk);
            #1;
            s_ack = 1'b0;
            m_cyc[exp_order[i]] = 1'b0;
            m_stb[exp_order[i]] = 1'b0;
            @(posedge clk);
            #1;
            n_checks++;
            if (grant !== 4'b0000) begin
                n_fail++;
                $display("FAIL rr_idle_gap_%0d: grant_o=%b, expected 0000", i, grant);
            end
            if (i < 3) begin
                m_cyc[exp_order[i]] = 1'b1;
                m_stb[exp_order[i]] = 1'b1;
            end else begin
                m_cyc = '0;
                m_stb = '0;
            end
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_enable();
        apply_reset();
        en = 4'b1001;
        drive_m(1, 1'b1, 1'b1, 1'b0, 10'h011, 32'h1, 4'hF);
        drive_m(3, 1'b1, 1'b1, 1'b0, 10'h033, 32'h3, 4'hF);
        @(posedge clk);
        #1;
        n_checks++;
        if (grant !== 4'b1000) begin
            n_fail++;
            $display("FAIL en_m3_grant: grant_o=%b, expected 1000", grant);
        end
        @(posedge clk);
        #1;
        en = 4'b1111;
        #1;
        n_checks++;
        if (grant !== 4'b1000 || s_adr !== 10'h033) begin
            n_fail++;
            $display("FAIL en_m3_hold: grant_o=%b adr=%h, expected 1000/033", grant, s_adr);
        end
        @(posedge clk);
        #1;
        m_cyc[3] = 1'b0;
        m_stb[3] = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL en_idle_gap: grant_o=%b, expected 0000", grant);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (grant !== 4'b0010 || s_adr !== 10'h011) begin
            n_fail++;
            $display("FAIL en_m1_grant: grant_o=%b adr=%h, expected 0010/011", grant, s_adr);
        end
        m_cyc = '0;
        m_stb = '0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_burst();
        apply_reset();
        drive_m(2, 1'b1, 1'b1, 1'b1, 10'h100, 32'hA5A5A5A5, 4'b0011);
        for (int b = 0; b < 4; b++) begin
            @(posedge clk);
            #1;
            if (b == 0) drive_m(0, 1'b1, 1'b1, 1'b0, 10'h3FF, 32'h0, 4'hF);
            m_adr[2*AW +: AW] = 10'h100 + AW'(b);
            s_ack = 1'b1;
            #1;
            n_checks++;
            if (grant !== 4'b0100 || m_ack !== 4'b0100) begin
                n_fail++;
                $display("FAIL burst_beat_%0d: grant_o=%b m_ack_o=%b, expected 0100/0100", b, grant, m_ack);
            end
            n_checks++;
            if (s_adr !== 10'h100 + AW'(b) || s_sel !== 4'b0011) begin
                n_fail++;
                $display("FAIL burst_mux_%0d: adr=%h sel=%b, expected %h/0011", b, s_adr, s_sel, 10'h100 + AW'(b));
            end
        end
        @(posedge clk);
        #1;
        s_ack    = 1'b0;
        m_cyc[2] = 1'b0;
        m_stb[2] = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL burst_idle_gap: grant_o=%b, expected 0000", grant);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (grant !== 4'b0001 || s_adr !== 10'h3FF) begin
            n_fail++;
            $display("FAIL burst_m0_after: grant_o=%b adr=%h, expected 0001/3ff", grant, s_adr);
        end
        m_cyc = '0;
        m_stb = '0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_timeout();
        apply_reset();
        drive_m(0, 1'b1, 1'b1, 1'b0, 10'h000, 32'h0, 4'hF);
        drive_m(1, 1'b1, 1'b1, 1'b0, 10'h001, 32'h0, 4'hF);
        for (int n = 1; n < TO; n++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (m_err !== 4'b0000 || grant !== 4'b0001 || s_stb !== 1'b1) begin
                n_fail++;
                $display("FAIL wdog_stall_%0d: m_err_o=%b grant_o=%b stb=%b, expected 0000/0001/1", n, m_err, grant, s_stb);
            end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (m_err !== 4'b0001 || s_cyc !== 1'b0 || s_stb !== 1'b0) begin
            n_fail++;
            $display("FAIL wdog_fire: m_err_o=%b cyc=%b stb=%b, expected 0001/0/0", m_err, s_cyc, s_stb);
        end
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (grant !== 4'b0000 || m_err !== 4'b0000) begin
            n_fail++;
            $display("FAIL wdog_idle: grant_o=%b m_err_o=%b, expected 0000/0000", grant, m_err);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL wdog_next_grant: grant_o=%b, expected 0010", grant);
        end
        // m1 now stalls; an ack on its final allowed cycle must beat the watchdog.
        for (int n = 2; n < TO; n++) @(posedge clk);
        @(posedge clk);
        #1;
        s_ack = 1'b1;
        #1;
        n_checks++;
        if (m_err !== 4'b0000 || m_ack !== 4'b0010 || s_stb !== 1'b1) begin
            n_fail++;
            $display("FAIL wdog_ack_wins: m_err_o=%b m_ack_o=%b stb=%b, expected 0000/0010/1", m_err, m_ack, s_stb);
        end
        @(posedge clk);
        #1;
        s_ack = 1'b0;
        #1;
        n_checks++;
        if (m_err !== 4'b0000 || grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL wdog_cleared: m_err_o=%b grant_o=%b, expected 0000/0010", m_err, grant);
        end
        m_cyc = '0;
        m_stb = '0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_async_reset();
        apply_reset();
        drive_m(2, 1'b1, 1'b1, 1'b1, 10'h222, 32'hCAFEF00D, 4'hF);
        @(posedge clk);
        #1;
        drive_m(0, 1'b1, 1'b1, 1'b0, 10'h00A, 32'h0, 4'hF);
        s_ack = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (grant !== 4'b0000 || s_cyc !== 1'b0 || s_stb !== 1'b0 || m_ack !== 4'b0000 || s_adr !== 10'h000) begin
            n_fail++;
            $display("FAIL async_reset: grant_o=%b cyc=%b stb=%b ack=%b adr=%h, expected all 0",
                     grant, s_cyc, s_stb, m_ack, s_adr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        s_ack = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL post_reset_priority: grant_o=%b, expected 0001", grant);
        end
        m_cyc = '0;
        m_stb = '0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_enable();
        test_burst();
        test_timeout();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rambus_arbiter.md
Name: rambus_arbiter

Overview:
- Round-robin Wishbone arbiter that shares the single OpenRAM wrapper port B ("rambus") between up to NUM_MASTERS user-project masters.
- Sits in user_project_wrapper between the user-project rambus master ports and wb_openram_wrapper port B.
- Only masters enabled by their active bit may win arbitration.
- A watchdog ends any granted transaction whose slave never acks, so one master cannot lock the RAM.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..8)
ADDR_WIDTH, 10, rambus address width
DATA_WIDTH, 32, data width; sel width is DATA_WIDTH/8
TIMEOUT, 255, max cycles a strobed access may wait for ack before forced termination (1..255)

Ports:
wb_clk_i  in  1  sole clock
wb_rst_n_i  in  1  asynchronous active-low reset
en_i  in  NUM_MASTERS  per-master enable (active bits)
m_cyc_i  in  NUM_MASTERS  master cycle
m_stb_i  in  NUM_MASTERS  master strobe
m_we_i  in  NUM_MASTERS  master write enable
m_sel_i  in  NUM_MASTERS*4  byte selects, master k at [4k+3:4k]
m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  addresses, packed likewise
m_dat_i  in  NUM_MASTERS*DATA_WIDTH  write data, packed likewise
m_ack_o  out  NUM_MASTERS  ack to granted master only
m_err_o  out  NUM_MASTERS  timeout termination pulse to granted master
m_dat_o  out  DATA_WIDTH  read data broadcast; valid only with own ack
s_cyc_o  out  1  to RAM wrapper
s_stb_o  out  1
s_we_o  out  1
s_sel_o  out  4
s_adr_o  out  ADDR_WIDTH
s_dat_o  out  DATA_WIDTH
s_ack_i  in  1
s_dat_i  in  DATA_WIDTH
grant_o  out  NUM_MASTERS  one-hot current grant, for debug/LA

Behaviour:
- Reset (async, wb_rst_n_i low):
  - state=IDLE, grant_o=0, last-grant pointer=NUM_MASTERS-1, so master 0 has first priority.
  - Watchdog=0; all s_* and m_ack_o/m_err_o outputs 0.
- Requester set: req[k] = m_cyc_i[k] & en_i[k].
- State IDLE:
  - If req is nonzero, select the first set bit searching upward from pointer+1 with wrap-around.
  - Register the winner into grant_o and go to GRANT. The grant is visible the cycle after req is sampled.
  - If no request, stay in IDLE with grant_o=0.
- State GRANT (granted master g):
  - s_cyc_o = m_cyc_i[g].
  - s_stb_o = m_stb_i[g].
  - s_we_o, s_sel_o, s_adr_o, s_dat_o are combinational muxes of master g's signals.
  - m_ack_o[g] = s_ack_i, combinational; all other acks 0.
  - m_dat_o = s_dat_i.
  - The grant persists across multiple strobes (burst) while m_cyc_i[g]=1.
  - Dropping en_i[g] mid-grant does not revoke the grant; en_i only gates new grants.
- Release:
  - When m_cyc_i[g]=0, go to IDLE, set pointer=g, and clear grant_o on the next edge.
  - One mandatory IDLE cycle follows between grants. No same-cycle handover.
- Watchdog:
  - Counts cycles in GRANT with s_stb_o=1 and s_ack_i=0; clears on ack or when stb is low.
  - On reaching TIMEOUT: pulse m_err_o[g] for 1 cycle, force s_cyc_o/s_stb_o to 0 that cycle, set pointer=g, go to IDLE.
  - Master g must then drop cyc. If it keeps cyc high it is only re-granted in round-robin order.
- Simultaneous events:
  - Ack on the same cycle the watchdog hits TIMEOUT: the ack wins and the watchdog clears.
  - Requests arriving while in GRANT wait; nothing is queued beyond req levels.
- Outside GRANT: all s_* outputs 0; m_dat_o = s_dat_i (don't-care).

Decomposition:
- Package rambus_pkg:
  - Constants RAMBUS_ADDR_W=10, RAMBUS_DATA_W=32, RAMBUS_SEL_W=4.
  - State enum {ARB_IDLE, ARB_GRANT}.
  - Watchdog width constant WDOG_W=8.
- Sub-module rr_pick: purely combinational round-robin one-hot selector (req, pointer -> one-hot winner, valid). Reused by future shared-resource arbiters.

Test Plan:
- Reset with all inputs idle, release reset -> grant_o=0, all s_* 0; m0 asserts cyc/stb/we, adr=0x005, dat=0xDEADBEEF -> grant_o=0001 next cycle, s_adr_o=0x005, s_dat_o=0xDEADBEEF, m_ack_o[0] follows s_ack_i.
- m0, m1, m2 request continuously, each dropping cyc after 1 acked access -> grant order 0,1,2,0,... with exactly one IDLE cycle between grants.
- m1 requests with en_i[1]=0, m3 requests with en_i[3]=1 -> m3 granted, m1 never granted; raise en_i[1] -> m1 granted after m3 releases.
- m2 granted for a 4-beat burst (stb high, cyc held) -> grant_o stays 0100 for all 4 acks although m0 requests; m0 is granted only after m2 drops cyc.
- TIMEOUT=8, slave never acks m0 -> m_err_o[0] pulses on the 8th stalled cycle, s_cyc_o drops, and a waiting m1 is granted next.
- Assert wb_rst_n_i low mid-burst -> all outputs 0 immediately (async); after release, m0 has priority again.
